// File: rtl/heater_ctrl_multi.sv
// heater_ctrl_multi: multi-channel NTC heater controller. Each channel filters its ADC code,
// regulates to a commanded setpoint (ONCE or HOLD) and latches over-temperature/runaway faults.
module heater_ctrl_multi #(
    parameter int N_CH       = 2,
    parameter int W          = 12,
    parameter int HOLDOFF    = 100,
    parameter int FILT_SHIFT = 4,
    parameter int RUNAWAY    = 1 << 20,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH*W-1:0] adc_in,
    input  logic [W-1:0]      hot_limit,
    input  logic              cmd_valid,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [1:0]        cmd_mode,
    input  logic [W-1:0]      cmd_target,
    input  logic [W-1:0]      cmd_band,
    output logic              cmd_err,
    output logic [N_CH-1:0]   heater_en,
    output logic [N_CH-1:0]   done,
    output logic [N_CH-1:0]   fault
);
    localparam int WAIT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int RUN_W  = $clog2(RUNAWAY + 1);

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_ONCE = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ONCE  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t            state_r  [N_CH];
    state_t            state_s  [N_CH];
    logic [W-1:0]      filt_r   [N_CH];
    logic [W-1:0]      filt_s   [N_CH];
    logic [W-1:0]      target_r [N_CH];
    logic [W-1:0]      target_s [N_CH];
    logic [W-1:0]      band_r   [N_CH];
    logic [W-1:0]      band_s   [N_CH];
    logic [1:0]        mode_r   [N_CH];
    logic [1:0]        mode_s   [N_CH];
    logic [WAIT_W-1:0] wait_r   [N_CH];
    logic [WAIT_W-1:0] wait_s   [N_CH];
    logic [RUN_W-1:0]  run_r    [N_CH];
    logic [RUN_W-1:0]  run_s    [N_CH];
    logic [N_CH-1:0]   heat_r, heat_s;
    logic [N_CH-1:0]   done_r, done_s;
    logic [N_CH-1:0]   fault_r, fault_s;
    logic [N_CH-1:0]   cmd_sel_s;
    logic              cmd_err_r;
    logic              ch_oob_s, ch_fault_s, run_mode_s, reject_s, accept_s;

    // One IIR step in signed W+1-bit arithmetic; the result always lies between filt and adc.
    function automatic logic [W-1:0] filt_step(input logic [W-1:0] filt, input logic [W-1:0] adc);
        logic signed [W:0] diff;
        logic signed [W:0] sum;
        diff = $signed({1'b0, adc}) - $signed({1'b0, filt});
        sum  = $signed({1'b0, filt}) + (diff >>> FILT_SHIFT);
        return sum[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[W] ? {W{1'b1}} : sum[W-1:0];
    endfunction

    // Hysteresis: off at or below target, on at or above target+band, otherwise hold.
    function automatic logic hold_heat(input logic [W-1:0] filt, input logic [W-1:0] target,
                                       input logic [W-1:0] band, input logic prev);
        logic res;
        if (filt <= target) begin
            res = 1'b0;
        end else if (filt >= sat_add(target, band)) begin
            res = 1'b1;
        end else begin
            res = prev;
        end
        return res;
    endfunction

    // Command validation against the addressed channel.
    always_comb begin
        ch_fault_s = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            ch_fault_s = ch_fault_s | ((int'(cmd_ch) == c) && (state_r[c] == ST_FAULT));
        end
        ch_oob_s   = (int'(cmd_ch) >= N_CH);
        run_mode_s = (cmd_mode == MODE_ONCE) || (cmd_mode == MODE_HOLD);
        reject_s   = ch_oob_s || (cmd_mode == MODE_RSVD) ||
                     (run_mode_s && ((cmd_target <= hot_limit) || ch_fault_s));
        accept_s   = cmd_valid & ~reject_s;
        for (int c = 0; c < N_CH; c++) begin
            cmd_sel_s[c] = accept_s & (int'(cmd_ch) == c);
        end
    end

    // Per-channel filter, fault supervision and regulation state machine.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_s[c]  = state_r[c];
            filt_s[c]   = filt_step(filt_r[c], adc_in[c*W +: W]);
            target_s[c] = target_r[c];
            band_s[c]   = band_r[c];
            mode_s[c]   = mode_r[c];
            wait_s[c]   = wait_r[c];
            run_s[c]    = heat_r[c] ? (run_r[c] + RUN_W'(1)) : {RUN_W{1'b0}};
            heat_s[c]   = heat_r[c];
            done_s[c]   = done_r[c];
            fault_s[c]  = fault_r[c];

            // Faults outrank commands and normal regulation in the same cycle.
            if ((((state_r[c] == ST_WAIT) || (state_r[c] == ST_ONCE) ||
                  (state_r[c] == ST_DONE) || (state_r[c] == ST_HOLD)) &&
                 (filt_r[c] <= hot_limit)) ||
                (heat_r[c] && (run_r[c] >= RUN_W'(RUNAWAY - 1)))) begin
                state_s[c] = ST_FAULT;
                heat_s[c]  = 1'b0;
                fault_s[c] = 1'b1;
            end else if (cmd_sel_s[c]) begin
                heat_s[c] = 1'b0;
                done_s[c] = 1'b0;
                if (cmd_mode == MODE_OFF) begin
                    state_s[c] = ST_OFF;
                    fault_s[c] = 1'b0;
                end else begin
                    state_s[c]  = ST_WAIT;
                    target_s[c] = cmd_target;
                    band_s[c]   = cmd_band;
                    mode_s[c]   = cmd_mode;
                    wait_s[c]   = WAIT_W'(HOLDOFF);
                end
            end else begin
                case (state_r[c])
                    ST_OFF: begin
                        heat_s[c] = 1'b0;
                    end
                    ST_WAIT: begin
                        heat_s[c] = 1'b0;
                        if (wait_r[c] > WAIT_W'(1)) begin
                            wait_s[c] = wait_r[c] - WAIT_W'(1);
                        end else begin
                            // The regulation decision is taken on the same edge the wait ends.
                            wait_s[c] = {WAIT_W{1'b0}};
                            if (mode_r[c] == MODE_ONCE) begin
                                if (filt_r[c] > target_r[c]) begin
                                    state_s[c] = ST_ONCE;
                                    heat_s[c]  = 1'b1;
                                end else begin
                                    state_s[c] = ST_DONE;
                                    done_s[c]  = 1'b1;
                                end
                            end else begin
                                state_s[c] = ST_HOLD;
                                heat_s[c]  = hold_heat(filt_r[c], target_r[c], band_r[c], 1'b0);
                            end
                        end
                    end
                    ST_ONCE: begin
                        if (filt_r[c] > target_r[c]) begin
                            heat_s[c] = 1'b1;
                        end else begin
                            state_s[c] = ST_DONE;
                            heat_s[c]  = 1'b0;
                            done_s[c]  = 1'b1;
                        end
                    end
                    ST_DONE: begin
                        heat_s[c] = 1'b0;
                        done_s[c] = 1'b1;
                    end
                    ST_HOLD: begin
                        heat_s[c] = hold_heat(filt_r[c], target_r[c], band_r[c], heat_r[c]);
                    end
                    ST_FAULT: begin
                        heat_s[c]  = 1'b0;
                        fault_s[c] = 1'b1;
                    end
                    default: begin
                        state_s[c] = ST_OFF;
                        heat_s[c]  = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset abandons any operation in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                state_r[c]  <= ST_OFF;
                filt_r[c]   <= {W{1'b1}};
                target_r[c] <= {W{1'b0}};
                band_r[c]   <= {W{1'b0}};
                mode_r[c]   <= MODE_OFF;
                wait_r[c]   <= {WAIT_W{1'b0}};
                run_r[c]    <= {RUN_W{1'b0}};
            end
            heat_r    <= {N_CH{1'b0}};
            done_r    <= {N_CH{1'b0}};
            fault_r   <= {N_CH{1'b0}};
            cmd_err_r <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_r[c]  <= state_s[c];
                filt_r[c]   <= filt_s[c];
                target_r[c] <= target_s[c];
                band_r[c]   <= band_s[c];
                mode_r[c]   <= mode_s[c];
                wait_r[c]   <= wait_s[c];
                run_r[c]    <= run_s[c];
            end
            heat_r    <= heat_s;
            done_r    <= done_s;
            fault_r   <= fault_s;
            cmd_err_r <= cmd_valid & reject_s;
        end
    end

    assign heater_en = heat_r;
    assign done      = done_r;
    assign fault     = fault_r;
    assign cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_heater_ctrl_multi.sv
// Bench for heater_ctrl_multi: directed scenarios with literal expectations plus randomised
// traffic, all compared every cycle against an event/time-based behavioural model.
`timescale 1ns/1ps
module tb_heater_ctrl_multi;
    localparam int N_CH = 2, W = 12, HOLDOFF = 100, FILT_SHIFT = 0, RUNAWAY = 1000;
    localparam int P_OFF = 0, P_WAIT = 1, P_ONCE = 2, P_DONE = 3, P_HOLD = 4, P_FAULT = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH*W-1:0] adc_in;
    logic [W-1:0]      hot_limit;
    logic              cmd_valid;
    logic [0:0]        cmd_ch;
    logic [1:0]        cmd_mode;
    logic [W-1:0]      cmd_target;
    logic [W-1:0]      cmd_band;
    logic              cmd_err;
    logic [N_CH-1:0]   heater_en, done, fault;

    heater_ctrl_multi #(
        .N_CH(N_CH), .W(W), .HOLDOFF(HOLDOFF), .FILT_SHIFT(FILT_SHIFT), .RUNAWAY(RUNAWAY)
    ) dut (
        .clk(clk), .reset(reset), .adc_in(adc_in), .hot_limit(hot_limit),
        .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_mode(cmd_mode),
        .cmd_target(cmd_target), .cmd_band(cmd_band), .cmd_err(cmd_err),
        .heater_en(heater_en), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase, setpoints and time stamps of wait start / heater-on start.
    int edge_n;
    int m_ph[N_CH], m_filt[N_CH], m_tgt[N_CH], m_bnd[N_CH], m_md[N_CH];
    int m_wstart[N_CH], m_hstart[N_CH];
    bit m_heat[N_CH], m_done[N_CH], m_flt[N_CH];
    bit m_err;
    int adcv[N_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        m_err  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            m_ph[c] = P_OFF; m_filt[c] = 4095; m_tgt[c] = 0; m_bnd[c] = 0; m_md[c] = 0;
            m_wstart[c] = 0; m_hstart[c] = 0;
            m_heat[c] = 1'b0; m_done[c] = 1'b0; m_flt[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit rej;
        int ch;
        edge_n++;
        ch  = int'(cmd_ch);
        rej = (ch >= N_CH) || (cmd_mode == 2'd3) ||
              (((cmd_mode == 2'd1) || (cmd_mode == 2'd2)) &&
               ((int'(cmd_target) <= int'(hot_limit)) || (m_ph[ch] == P_FAULT)));
        m_err = cmd_valid && rej;
        for (int c = 0; c < N_CH; c++) begin
            int f; int a; int hi; int p; bit nh; bit hit;
            f   = m_filt[c];
            a   = int'(adc_in[c*W +: W]);
            nh  = m_heat[c];
            hit = cmd_valid && !rej && (ch == c);
            if ((m_ph[c] >= P_WAIT && m_ph[c] <= P_HOLD && f <= int'(hot_limit)) ||
                (m_heat[c] && (edge_n - m_hstart[c] >= RUNAWAY))) begin
                m_ph[c] = P_FAULT; nh = 1'b0; m_flt[c] = 1'b1;
            end else if (hit && cmd_mode == 2'd0) begin
                m_ph[c] = P_OFF; nh = 1'b0; m_flt[c] = 1'b0; m_done[c] = 1'b0;
            end else if (hit) begin
                m_tgt[c] = int'(cmd_target); m_bnd[c] = int'(cmd_band); m_md[c] = int'(cmd_mode);
                m_done[c] = 1'b0; m_wstart[c] = edge_n; m_ph[c] = P_WAIT; nh = 1'b0;
            end else begin
                p  = m_ph[c];
                hi = m_tgt[c] + m_bnd[c];
                if (hi > 4095) hi = 4095;
                if (p == P_WAIT && edge_n - m_wstart[c] >= HOLDOFF) p = (m_md[c] == 1) ? P_ONCE : P_HOLD;
                if (p == P_ONCE) begin
                    if (f > m_tgt[c]) nh = 1'b1;
                    else begin nh = 1'b0; m_done[c] = 1'b1; p = P_DONE; end
                end else if (p == P_HOLD) begin
                    if (f <= m_tgt[c]) nh = 1'b0;
                    else if (f >= hi) nh = 1'b1;
                end else begin
                    nh = 1'b0;
                end
                m_ph[c] = p;
            end
            if (nh && !m_heat[c]) m_hstart[c] = edge_n;
            m_heat[c] = nh;
            m_filt[c] = f + ((a - f) >>> FILT_SHIFT);
        end
    endtask

    task automatic compare();
        logic [N_CH-1:0] eh, ed, ef;
        for (int c = 0; c < N_CH; c++) begin
            eh[c] = m_heat[c]; ed[c] = m_done[c]; ef[c] = m_flt[c];
        end
        chk("heater_en", 32'(heater_en), 32'(eh));
        chk("done", 32'(done), 32'(ed));
        chk("fault", 32'(fault), 32'(ef));
        chk("cmd_err", 32'(cmd_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
        cmd_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_adc(input int c, input int v);
        adcv[c] = v;
        adc_in[c*W +: W] = 12'(v);
    endtask

    task automatic send(input int ch, input int mode, input int tgt, input int bnd);
        cmd_valid  = 1'b1;
        cmd_ch     = 1'(ch);
        cmd_mode   = 2'(mode);
        cmd_target = 12'(tgt);
        cmd_band   = 12'(bnd);
        tick();
    endtask

    initial begin
        int n;
        reset = 1'b1; hot_limit = 12'd500; cmd_valid = 1'b0; cmd_ch = 1'b0;
        cmd_mode = 2'd0; cmd_target = 12'd0; cmd_band = 12'd0; adc_in = '0;
        set_adc(0, 3000); set_adc(1, 3000);
        model_reset();
        #3;
        chk("reset_heater", 32'(heater_en), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        ticks(2);
        reset = 1'b0;
        ticks(3);

        // V1: ONCE on ch0, heater rises exactly HOLDOFF cycles after acceptance.
        set_adc(0, 2500); ticks(2);
        send(0, 1, 1800, 0);
        ticks(99);
        chk("v1_wait_end", 32'(heater_en[0]), 32'd0);
        tick();
        chk("v1_heat_on", 32'(heater_en[0]), 32'd1);
        ticks(20);
        set_adc(0, 1800); tick();
        chk("v1_one_cycle", 32'(heater_en[0]), 32'd1);
        tick();
        chk("v1_heat_off", 32'(heater_en[0]), 32'd0);
        chk("v1_done", 32'(done[0]), 32'd1);
        chk("v1_ch1_heat", 32'(heater_en[1]), 32'd0);
        chk("v1_ch1_done", 32'(done[1]), 32'd0);

        // V2: HOLD hysteresis on ch1.
        set_adc(1, 2000); ticks(2);
        send(1, 2, 1800, 50);
        ticks(100);
        chk("v2_2000", 32'(heater_en[1]), 32'd1);
        set_adc(1, 1790); ticks(2);
        chk("v2_1790", 32'(heater_en[1]), 32'd0);
        set_adc(1, 1820); ticks(3);
        chk("v2_1820", 32'(heater_en[1]), 32'd0);
        set_adc(1, 1860); ticks(2);
        chk("v2_1860", 32'(heater_en[1]), 32'd1);

        // V3: over-temperature fault, rejected ONCE, OFF clears.
        set_adc(1, 400); ticks(2);
        chk("v3_fault", 32'(fault[1]), 32'd1);
        chk("v3_heat", 32'(heater_en[1]), 32'd0);
        send(1, 1, 1800, 0);
        chk("v3_cmd_err", 32'(cmd_err), 32'd1);
        chk("v3_fault_kept", 32'(fault[1]), 32'd1);
        tick();
        chk("v3_err_pulse", 32'(cmd_err), 32'd0);
        set_adc(1, 3000); tick();
        send(1, 0, 0, 0);
        chk("v3_fault_clr", 32'(fault[1]), 32'd0);

        // V4: runaway (target above hot_limit, never reached).
        set_adc(0, 3000); ticks(2);
        send(0, 1, 600, 0);
        n = 0;
        while (!heater_en[0] && n < 200) begin tick(); n++; end
        chk("v4_rise", 32'(n), 32'd100);
        n = 0;
        while (!fault[0] && n < 1100) begin tick(); n++; end
        chk("v4_runaway", 32'(n), 32'd1000);
        chk("v4_heat_off", 32'(heater_en[0]), 32'd0);
        send(0, 0, 0, 0);

        // V5: command rejections (cmd_ch cannot exceed N_CH-1 with a 1-bit port).
        send(0, 1, 450, 0);
        chk("v5_low_tgt", 32'(cmd_err), 32'd1);
        send(0, 2, 500, 0);
        chk("v5_eq_limit", 32'(cmd_err), 32'd1);
        send(0, 3, 1800, 0);
        chk("v5_mode3", 32'(cmd_err), 32'd1);
        chk("v5_no_change", 32'(heater_en), 32'd0);
        send(0, 1, 501, 0);
        chk("v5_accept", 32'(cmd_err), 32'd0);
        ticks(3);
        send(0, 0, 0, 0);

        // Saturated hysteresis threshold: 4000+200 clips to 4095.
        set_adc(1, 4050); ticks(2);
        send(1, 2, 4000, 200);
        ticks(100);
        chk("sat_mid", 32'(heater_en[1]), 32'd0);
        set_adc(1, 4095); ticks(2);
        chk("sat_top", 32'(heater_en[1]), 32'd1);
        send(1, 0, 0, 0);

        // V6: asynchronous reset mid-HOLD (ch1) and mid-WAIT (ch0).
        hot_limit = 12'd200;
        set_adc(1, 3000); ticks(2);
        send(1, 2, 1800, 50);
        ticks(101);
        set_adc(0, 2500);
        send(0, 1, 1800, 0);
        ticks(50);
        chk("v6_pre_heat", 32'(heater_en[1]), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("v6_async_heat", 32'(heater_en), 32'd0);
        chk("v6_async_done", 32'(done), 32'd0);
        chk("v6_async_fault", 32'(fault), 32'd0);
        chk("v6_async_err", 32'(cmd_err), 32'd0);
        model_reset();
        ticks(3);
        reset = 1'b0;
        ticks(150);
        chk("v6_off_heat", 32'(heater_en), 32'd0);
        chk("v6_off_done", 32'(done), 32'd0);

        // Randomised traffic: ADC random walk with occasional jumps and sporadic commands.
        hot_limit = 12'd500;
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                int v;
                if ($urandom_range(99) == 0) v = int'($urandom_range(4095));
                else v = adcv[c] + int'($urandom_range(80)) - 40;
                if (v < 0) v = 0;
                if (v > 4095) v = 4095;
                set_adc(c, v);
            end
            if ($urandom_range(149) == 0) begin
                cmd_valid  = 1'b1;
                cmd_ch     = 1'($urandom_range(1));
                cmd_mode   = 2'($urandom_range(3));
                cmd_target = 12'($urandom_range(4095, 300));
                cmd_band   = 12'($urandom_range(300));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
